alu_control_sequencer: RTL and testbench
========================================

Name: alu_control_sequencer

Overview:
- Moore control unit that drives the DataPath control strobes for instruction fetch and three-register ALU execution.
- Replaces hand-timed strobe sequences with a clocked T-state machine.
- Decodes the IR contents presented by the DataPath and waits on a memory-ready handshake during fetch.
- Supports run/stop, HALT, NOP, MUL/DIV with HI/LO writeback, and illegal-opcode/memory-timeout error trapping.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent in T1 waiting for MemReady before trapping to ERROR (1..255).

Ports:
- Clock  in  1  system clock, rising edge
- Clear  in  1  asynchronous active-high reset
- Start  in  1  begin execution from IDLE
- Stop  in  1  request halt at next instruction boundary
- IR  in  32  DataPath instruction register; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]
- MemReady  in  1  memory data valid on Mdatain this cycle
- PCout, ZHighout, Zlowout, MDRout  out  1 each  bus drive enables
- Rout  out  16  one-hot register bus drive
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn  out  1 each  load enables
- Rin  out  16  one-hot register load
- IncPC, Read  out  1 each  PC increment, memory read
- ALUop  out  5  ALU operation select
- Running  out  1  high in T0..T6
- Err  out  1  high in ERROR

Behaviour:
- Clock and reset: single clock Clock; reset Clear is asynchronous, active-high. While Clear is high: state=IDLE, timeout counter=0, every output 0.
- Output decoding: all outputs are decoded from the state register only (Moore); no input-to-output combinational path except IR field decode in T3..T6.
- IR validity: IR is valid from T3 onward, having been loaded at the end of T2.
- Decode:
  - Opcode 00000..01110: ALU op.
  - 01111 MUL, 10000 DIV: wide ops.
  - 11010 NOP.
  - 11011 HALT.
  - All others: illegal.
- States and per-state actions:
  - IDLE: all outputs 0. Start=1 -> T0.
  - T0: PCout, MARin, IncPC, PCin. -> T1.
  - T1: Read, MDRin held every cycle. MemReady=1 -> T2, counter cleared. Otherwise counter increments; counter reaching MEM_TIMEOUT with no MemReady -> ERROR.
  - T2: MDRout, IRin. -> T3.
  - T3: decode.
    - ALU, MUL, DIV: Rout[Rb]=1, Yin. -> T4.
    - NOP: no strobes; boundary check.
    - HALT: -> HALTED.
    - Illegal: -> ERROR.
  - T4: Rout[Rc]=1, ALUop=opcode, ZLowIn. ZHighIn also asserted for MUL/DIV. -> T5.
  - T5:
    - ALU ops: Zlowout, Rin[Ra]=1; boundary check.
    - MUL/DIV: Zlowout, LOin. -> T6.
  - T6: ZHighout, HIin; boundary check.
  - HALTED: Running=0. Start=1 -> T0. Err stays 0.
  - ERROR: Err=1, all strobes 0. Exit only via Clear.
- Boundary check: leaving T5 (ALU op), T6, or T3 (NOP) goes to IDLE if Stop=1, otherwise to T0.
- Stop timing: Stop sampled elsewhere has no effect; it must be high in the boundary cycle to take effect.
- Start: ignored outside IDLE and HALTED.
- Exclusivity: at most one bus driver (PCout, ZHighout, Zlowout, MDRout, Rout bits) is high in any cycle. Rout and Rin are one-hot or zero.
- R0: a legal source and destination; no special casing.
- Reset mid-instruction: Clear in any state aborts immediately and all strobes drop asynchronously. No partial writeback occurs after Clear deasserts.
- Latency (MemReady first cycle):
  - ALU instruction: 6 cycles, T0..T5.
  - MUL/DIV: 7 cycles.
  - NOP: 4 cycles.
  - Each extra T1 wait adds 1 cycle.

Test Plan:
- AND R1,R2,R3: Clear pulse, Start; IR=0x28918000, MemReady high in T1 -> strobes in order:
  - PCout/MARin/IncPC/PCin
  - Read/MDRin
  - MDRout/IRin
  - Rout=0x0004/Yin
  - Rout=0x0008/ALUop=00101/ZLowIn
  - Zlowout/Rin=0x0002
  - then T0 again; bench DataPath with R2=0x12, R3=0x14 yields R1=0x10.
- Memory wait: MemReady delayed 3 cycles -> Read/MDRin held 4 cycles, then T2. MemReady never asserted -> Err=1 after MEM_TIMEOUT (15) T1 cycles, all strobes 0.
- MUL R4,R5,R6 (opcode 01111): T4 asserts both ZLowIn and ZHighIn; T5 Zlowout+LOin; T6 ZHighout+HIin; Rin stays 0 throughout.
- HALT (opcode 11011) -> Running=0 after T3, no writes. Start=1 -> fetch resumes at T0. Illegal opcode 11111 -> ERROR, Err=1 until Clear.
- Stop=1 held during T5 of an ADD -> IDLE next cycle. Stop=1 pulsed only during T2 -> ignored, next T0 fetched.
- Clear asserted mid-T4 (between clock edges) -> all outputs 0 immediately. After release, state stays IDLE with no Rin/LOin pulse until Start.

Source files
------------

// File: rtl/alu_control_sequencer.sv
// Moore T-state control unit driving DataPath strobes for instruction fetch and
// three-register ALU / MUL / DIV execution, with memory-wait timeout and error trap.
module alu_control_sequencer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        Clock,
   input  logic        Clear,
   input  logic        Start,
   input  logic        Stop,
   input  logic [31:0] IR,
   input  logic        MemReady,
   output logic        PCout,
   output logic        ZHighout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic [15:0] Rout,
   output logic        MARin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        HIin,
   output logic        LOin,
   output logic        ZHighIn,
   output logic        ZLowIn,
   output logic [15:0] Rin,
   output logic        IncPC,
   output logic        Read,
   output logic [4:0]  ALUop,
   output logic        Running,
   output logic        Err
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED, S_ERROR
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       is_alu, is_wide, is_nop, is_halt;
   logic       unused_ir_bits;

   assign opcode         = IR[31:27];
   assign ra             = IR[26:23];
   assign rb             = IR[22:19];
   assign rc             = IR[18:15];
   assign unused_ir_bits = ^IR[14:0];

   assign is_alu  = (opcode <= 5'd14);
   assign is_wide = (opcode == 5'd15) || (opcode == 5'd16);
   assign is_nop  = (opcode == 5'd26);
   assign is_halt = (opcode == 5'd27);

   // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE, S_HALTED: if (Start) state_d = S_T0;
         S_T0: begin
            state_d = S_T1;
            cnt_d   = '0;
         end
         S_T1: begin
            if (MemReady) begin
               state_d = S_T2;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d = S_ERROR;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_T2: state_d = S_T3;
         S_T3: begin
            if (is_alu || is_wide) state_d = S_T4;
            else if (is_nop)       state_d = Stop ? S_IDLE : S_T0;
            else if (is_halt)      state_d = S_HALTED;
            else                   state_d = S_ERROR;
         end
         S_T4: state_d = S_T5;
         S_T5: begin
            if (is_wide) state_d = S_T6;
            else         state_d = Stop ? S_IDLE : S_T0;
         end
         S_T6:    state_d = Stop ? S_IDLE : S_T0;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_ERROR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Strobes come from the state register alone; IR only selects register index and ALU op.
   always_comb begin
      PCout    = 1'b0;
      ZHighout = 1'b0;
      Zlowout  = 1'b0;
      MDRout   = 1'b0;
      Rout     = '0;
      MARin    = 1'b0;
      PCin     = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      ZHighIn  = 1'b0;
      ZLowIn   = 1'b0;
      Rin      = '0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      ALUop    = '0;
      Running  = 1'b0;
      Err      = 1'b0;
      unique case (state_q)
         S_T0: begin
            Running = 1'b1;
            PCout   = 1'b1;
            MARin   = 1'b1;
            IncPC   = 1'b1;
            PCin    = 1'b1;
         end
         S_T1: begin
            Running = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            Running = 1'b1;
            MDRout  = 1'b1;
            IRin    = 1'b1;
         end
         S_T3: begin
            Running = 1'b1;
            if (is_alu || is_wide) begin
               Rout = 16'd1 << rb;
               Yin  = 1'b1;
            end
         end
         S_T4: begin
            Running = 1'b1;
            Rout    = 16'd1 << rc;
            ALUop   = opcode;
            ZLowIn  = 1'b1;
            ZHighIn = is_wide;
         end
         S_T5: begin
            Running = 1'b1;
            Zlowout = 1'b1;
            if (is_wide) LOin = 1'b1;
            else         Rin  = 16'd1 << ra;
         end
         S_T6: begin
            Running  = 1'b1;
            ZHighout = 1'b1;
            HIin     = 1'b1;
         end
         S_ERROR: Err = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Self-checking bench: an instruction-level model expands each instruction into its
// expected strobe sequence, and a small DataPath model checks the resulting register writes.
module tb_alu_control_sequencer;

   typedef struct packed {
      logic        pc_out, zhi_out, zlo_out, mdr_out;
      logic [15:0] r_out;
      logic        mar_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, zhi_in, zlo_in;
      logic [15:0] r_in;
      logic        inc_pc, read;
      logic [4:0]  alu_op;
      logic        running, err;
   } ctl_t;

   logic        Clock = 1'b0;
   logic        Clear, Start, Stop, MemReady;
   logic [31:0] IR;
   logic        PCout, ZHighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin;
   logic        HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Running, Err;
   logic [15:0] Rout, Rin;
   logic [4:0]  ALUop;

   int total = 0;
   int bad   = 0;

   ctl_t  dut_vec;
   ctl_t  exp_cur;
   string exp_tag;
   logic  exp_valid;
   string stop_ph;

   logic [31:0] rf [16];
   logic [31:0] y_r, zlo_r, zhi_r, hi_r, lo_r, bus;
   logic [63:0] alu_res;
   logic        dp_load;

   always #5 Clock = ~Clock;

   alu_control_sequencer #(.MEM_TIMEOUT(15)) dut (
      .Clock(Clock), .Clear(Clear), .Start(Start), .Stop(Stop), .IR(IR), .MemReady(MemReady),
      .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout), .Rout(Rout),
      .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
      .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Rin(Rin), .IncPC(IncPC),
      .Read(Read), .ALUop(ALUop), .Running(Running), .Err(Err)
   );

   assign dut_vec = {PCout, ZHighout, Zlowout, MDRout, Rout, MARin, PCin, MDRin, IRin, Yin,
                     HIin, LOin, ZHighIn, ZLowIn, Rin, IncPC, Read, ALUop, Running, Err};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Bench DataPath: one shared bus, Y/Z latches, HI/LO and a 16-entry register file.
   always_comb begin
      bus = 32'h0;
      for (int i = 0; i < 16; i++) if (Rout[i]) bus = bus | rf[i];
      if (Zlowout)  bus = bus | zlo_r;
      if (ZHighout) bus = bus | zhi_r;
      case (ALUop)
         5'd5:    alu_res = {32'h0, y_r & bus};
         5'd15:   alu_res = {32'h0, y_r} * {32'h0, bus};
         5'd16:   alu_res = (bus == 0) ? 64'h0 : {y_r % bus, y_r / bus};
         default: alu_res = {32'h0, y_r + bus};
      endcase
   end

   always @(posedge Clock) begin
      if (dp_load) begin
         for (int i = 0; i < 16; i++) rf[i] <= 32'h11 * i;
         rf[2] <= 32'h12;
         rf[3] <= 32'h14;
         rf[5] <= 32'h0001_0000;
         rf[6] <= 32'h0003_0000;
         y_r <= 0; zlo_r <= 0; zhi_r <= 0; hi_r <= 32'hAAAA; lo_r <= 32'h5555;
      end else begin
         if (Yin)     y_r   <= bus;
         if (ZLowIn)  zlo_r <= alu_res[31:0];
         if (ZHighIn) zhi_r <= alu_res[63:32];
         if (HIin)    hi_r  <= bus;
         if (LOin)    lo_r  <= bus;
         for (int i = 0; i < 16; i++) if (Rin[i]) rf[i] <= bus;
      end
   end

   // Single compare process, away from the active edge.
   always @(negedge Clock) begin
      if (exp_valid) begin
         check($sformatf("ctl@%s", exp_tag), 64'(dut_vec), 64'(exp_cur));
         check($sformatf("bus_excl@%s", exp_tag),
               64'(int'(PCout) + int'(ZHighout) + int'(Zlowout) + int'(MDRout) + $countones(Rout) <= 1),
               64'd1);
      end
   end

   function automatic ctl_t act();
      ctl_t c = '0;
      c.running = 1'b1;
      return c;
   endfunction

   function automatic logic [31:0] enc(input int op, input int ra, input int rb, input int rc);
      return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'h0};
   endfunction

   task automatic step(input ctl_t c, input string tag, input logic boundary);
      Stop      = (tag == stop_ph) || (boundary && stop_ph == "END");
      exp_cur   = c;
      exp_tag   = tag;
      exp_valid = 1'b1;
      @(posedge Clock);
      #1;
      Stop = 1'b0;
   endtask

   // Entered at T0; returns one cycle after the instruction's last T-state.
   task automatic run_instr(input logic [31:0] ins, input int wt, input string sph,
                            input logic start_hold, input logic abort_t4);
      int   op, ra, rb, rc;
      ctl_t c;
      op = int'(ins[31:27]); ra = int'(ins[26:23]); rb = int'(ins[22:19]); rc = int'(ins[18:15]);
      stop_ph = sph;
      Start   = start_hold;
      c = act(); c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.pc_in = 1;
      step(c, "T0", 1'b0);
      for (int w = 0; w <= wt; w++) begin
         MemReady = (w == wt);
         c = act(); c.read = 1; c.mdr_in = 1;
         step(c, "T1", 1'b0);
      end
      MemReady = 1'b0;
      c = act(); c.mdr_out = 1; c.ir_in = 1;
      step(c, "T2", 1'b0);
      IR = ins;
      if (op <= 16) begin
         c = act(); c.r_out = 16'd1 << rb; c.y_in = 1;
         step(c, "T3", 1'b0);
         c = act(); c.r_out = 16'd1 << rc; c.alu_op = 5'(op); c.zlo_in = 1; c.zhi_in = (op >= 15);
         if (abort_t4) begin
            exp_valid = 1'b0;
            #1 check("t4_before_clear", 64'(dut_vec), 64'(c));
            #1 Clear = 1'b1;
            #1 check("async_clear_zero", 64'(dut_vec), 64'h0);
            return;
         end
         step(c, "T4", 1'b0);
         c = act(); c.zlo_out = 1;
         if (op >= 15) begin
            c.lo_in = 1;
            step(c, "T5", 1'b0);
            c = act(); c.zhi_out = 1; c.hi_in = 1;
            step(c, "T6", 1'b1);
         end else begin
            c.r_in = 16'd1 << ra;
            step(c, "T5", 1'b1);
         end
      end else begin
         step(act(), "T3", op == 26);
      end
      Start   = 1'b0;
      stop_ph = "";
   endtask

   task automatic idle_steps(input int n, input string tag, input logic err_exp);
      ctl_t c = '0;
      c.err = err_exp;
      for (int i = 0; i < n; i++) step(c, tag, 1'b0);
   endtask

   initial begin
      ctl_t c;
      Clear = 1'b1; Start = 1'b0; Stop = 1'b0; MemReady = 1'b0; IR = 32'h0;
      dp_load = 1'b1; exp_valid = 1'b0; stop_ph = ""; exp_tag = "";
      #3 check("reset_outputs", 64'(dut_vec), 64'h0);
      @(posedge Clock); #1 dp_load = 1'b0;
      @(negedge Clock) Clear = 1'b0;
      @(posedge Clock); #1;

      idle_steps(2, "IDLE", 1'b0);
      Start = 1'b1; idle_steps(1, "IDLE_start", 1'b0); Start = 1'b0;

      // AND R1,R2,R3 then NOP with three wait cycles, then MUL with Start held (ignored).
      run_instr(32'h2891_8000, 0, "", 1'b0, 1'b0);
      check("and_r1", 64'(rf[1]), 64'h10);
      run_instr(enc(26, 0, 0, 0), 3, "", 1'b0, 1'b0);
      run_instr(enc(15, 4, 5, 6), 0, "", 1'b1, 1'b0);
      check("mul_hi", 64'(hi_r), 64'h3);
      check("mul_lo", 64'(lo_r), 64'h0);
      check("mul_r4_untouched", 64'(rf[4]), 64'h44);

      // ADD R7 with Stop in the boundary cycle -> IDLE.
      run_instr(enc(0, 7, 2, 3), 0, "END", 1'b0, 1'b0);
      idle_steps(2, "IDLE_after_stop", 1'b0);
      check("add_r7", 64'(rf[7]), 64'h26);

      // Stop only in T2 is ignored; then HALT, resume, illegal opcode.
      Start = 1'b1; idle_steps(1, "IDLE_start", 1'b0);
      run_instr(enc(0, 9, 2, 3), 0, "T2", 1'b0, 1'b0);
      run_instr(enc(27, 1, 2, 3), 0, "", 1'b0, 1'b0);
      idle_steps(2, "HALTED", 1'b0);
      check("halt_r9_written", 64'(rf[9]), 64'h26);
      check("halt_r1_kept", 64'(rf[1]), 64'h10);
      Start = 1'b1; idle_steps(1, "HALTED_start", 1'b0);
      run_instr(enc(31, 1, 2, 3), 1, "", 1'b0, 1'b0);
      Start = 1'b1; idle_steps(3, "ERROR", 1'b1); Start = 1'b0;
      exp_valid = 1'b0;
      Clear = 1'b1;
      #2 check("clear_from_error", 64'(dut_vec), 64'h0);
      Clear = 1'b0;
      idle_steps(1, "IDLE_after_err", 1'b0);

      // Memory timeout: 15 T1 cycles without MemReady -> ERROR.
      Start = 1'b1; idle_steps(1, "IDLE_start", 1'b0); Start = 1'b0;
      c = act(); c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.pc_in = 1;
      step(c, "T0", 1'b0);
      c = act(); c.read = 1; c.mdr_in = 1;
      for (int i = 0; i < 15; i++) step(c, "T1_wait", 1'b0);
      idle_steps(3, "ERROR_timeout", 1'b0 == 1'b0);
      exp_valid = 1'b0;
      Clear = 1'b1;
      #2 Clear = 1'b0;
      idle_steps(1, "IDLE_after_timeout", 1'b0);

      // Clear mid-T4 of ADD R8: no writeback after release.
      Start = 1'b1; idle_steps(1, "IDLE_start", 1'b0);
      run_instr(enc(0, 8, 2, 3), 0, "", 1'b0, 1'b1);
      @(posedge Clock);
      @(negedge Clock) Clear = 1'b0;
      @(posedge Clock); #1;
      Start = 1'b0;
      idle_steps(4, "IDLE_after_abort", 1'b0);
      check("abort_r8_kept", 64'(rf[8]), 64'h88);
      check("abort_lo_kept", 64'(lo_r), 64'h0);

      exp_valid = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
